// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: valid/ready configuration channel for the clock divider controller
//   cfg_valid  master->slave  a new divide ratio is offered
//   cfg_div    master->slave  offered divide ratio N (W bits)
//   cfg_ready  slave->master  controller can accept a ratio
//   cfg_err    slave->master  one-cycle pulse: accepted ratio was illegal and dropped
interface clk_div_ctrl_if #(parameter int W = 8);
   logic         cfg_valid;
   logic [W-1:0] cfg_div;
   logic         cfg_ready;
   logic         cfg_err;
   modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
   modport slave (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a programmable integer clock divider
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   en       run request; low stops at the end of the current period
//   cfg      configuration channel (slave side)
//   div_out  divided output, high for cnt < N>>1
//   tick     one-cycle pulse in the last cycle of each period
//   active   controller is running or draining
//   cur_div  divide ratio currently in effect
module clk_div_ctrl #(
   parameter int W     = 8,
   parameter int DEF_N = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   clk_div_ctrl_if.slave  cfg,
   output logic           div_out,
   output logic           tick,
   output logic           active,
   output logic [W-1:0]   cur_div
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d, cur_q, cur_d, pdiv_q, pdiv_d;
   logic         pvld_q, pvld_d, err_d, div_q, div_d, tick_q, tick_d, act_q, act_d;
   logic         wrap, bnd, accept, legal, apply;
   assign wrap   = state_q != IDLE && cnt_q == cur_q - 1'b1;
   // a period boundary: idle, or the last cycle of a running period
   assign bnd    = state_q == IDLE || wrap;
   assign accept = cfg.cfg_valid && !pvld_q;
   assign legal  = |cfg.cfg_div[W-1:1];
   assign apply  = pvld_q && bnd;
   // next-cycle outputs are decoded from next-cycle state so the flops line up with cnt
   always_comb begin
      state_d = bnd ? (en ? RUN : IDLE) : (en ? RUN : DRAIN);
      cnt_d   = bnd ? '0 : cnt_q + 1'b1;
      cur_d   = apply ? pdiv_q : cur_q;
      pvld_d  = apply ? 1'b0 : pvld_q | (accept & legal);
      pdiv_d  = accept && legal ? cfg.cfg_div : pdiv_q;
      err_d   = accept & ~legal;
      act_d   = state_d != IDLE;
      div_d   = act_d && cnt_d < (cur_d >> 1);
      tick_d  = act_d && cnt_d == cur_d - 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cur_q         <= W'(DEF_N);
         pdiv_q        <= W'(DEF_N);
         pvld_q        <= 1'b0;
         div_q         <= 1'b0;
         tick_q        <= 1'b0;
         act_q         <= 1'b0;
         cfg.cfg_err   <= 1'b0;
         cfg.cfg_ready <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cur_q         <= cur_d;
         pdiv_q        <= pdiv_d;
         pvld_q        <= pvld_d;
         div_q         <= div_d;
         tick_q        <= tick_d;
         act_q         <= act_d;
         cfg.cfg_err   <= err_d;
         cfg.cfg_ready <= !pvld_d;
      end
   end
   assign div_out = div_q;
   assign tick    = tick_q;
   assign active  = act_q;
   assign cur_div = cur_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and randomized checks of clk_div_ctrl against a period-level model
module tb_clk_div_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       div_out, tick, active;
   logic [7:0] cur_div;
   int         n_chk = 0;
   int         n_err = 0;
   bit         m_run, m_err;
   int         m_pos, m_n;
   int         m_pend[$];

   clk_div_ctrl_if #(.W(8)) cif ();

   clk_div_ctrl #(.W(8), .DEF_N(7)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg(cif.slave),
      .div_out(div_out), .tick(tick), .active(active), .cur_div(cur_div)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // period-level model: a running flag, position inside the period, ratio and a one-deep queue
   task automatic model(input bit r, input bit e, input bit v, input int d);
      int had;
      if (r) begin
         m_run = 0; m_pos = 0; m_n = 7; m_err = 0;
         m_pend.delete();
         return;
      end
      had = m_pend.size();
      m_err = 0;
      if (!m_run || m_pos == m_n - 1) begin
         if (had != 0) m_n = m_pend.pop_front();
         m_pos = 0;
         m_run = e;
      end else m_pos++;
      if (v && had == 0) begin
         if (d >= 2) m_pend.push_back(d);
         else m_err = 1;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit v, input int d);
      rst = r; en = e; cif.cfg_valid = v; cif.cfg_div = 8'(d);
      @(posedge clk);
      model(r, e, v, d);
      #1;
      check("active", 32'(active), 32'(m_run));
      check("div_out", 32'(div_out), 32'(m_run && m_pos < m_n / 2));
      check("tick", 32'(tick), 32'(m_run && m_pos == m_n - 1));
      check("cur_div", 32'(cur_div), 32'(m_n));
      check("cfg_ready", 32'(cif.cfg_ready), 32'(m_pend.size() == 0));
      check("cfg_err", 32'(cif.cfg_err), 32'(m_err));
   endtask

   task automatic run_to(input int p, input bit e);
      for (int i = 0; i < 300 && !(m_run && m_pos == p); i++) step(0, e, 0, 0);
      check("reach_pos", 32'(m_pos), 32'(p));
   endtask

   initial begin
      cif.cfg_valid = 1'b0;
      cif.cfg_div = 8'd0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("rst_cur_div", 32'(cur_div), 32'd7);
      repeat (21) step(0, 1, 0, 0);
      run_to(2, 1);
      step(0, 1, 1, 4);
      check("ready_fall", 32'(cif.cfg_ready), 32'd0);
      repeat (16) step(0, 1, 0, 0);
      check("cur_div_4", 32'(cur_div), 32'd4);
      run_to(1, 1);
      repeat (5) step(0, 0, 0, 0);
      check("stopped", 32'(active), 32'd0);
      step(0, 1, 0, 0);
      run_to(1, 1);
      step(0, 0, 0, 0);
      repeat (8) step(0, 1, 0, 0);
      check("no_gap", 32'(active), 32'd1);
      repeat (6) step(0, 0, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("idle_cur", 32'(cur_div), 32'd4);
      step(1, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0);
      run_to(1, 1);
      step(0, 1, 1, 4);
      run_to(3, 1);
      step(1, 1, 0, 0);
      check("rst_mid_cur", 32'(cur_div), 32'd7);
      check("rst_mid_ready", 32'(cif.cfg_ready), 32'd1);
      repeat (2) step(0, 0, 0, 0);
      step(0, 0, 1, 255);
      repeat (600) step(0, 1, 0, 0);
      check("cur_div_255", 32'(cur_div), 32'd255);
      run_to(10, 1);
      step(0, 1, 1, 2);
      repeat (300) step(0, 1, 0, 0);
      check("cur_div_2", 32'(cur_div), 32'd2);
      for (int i = 0; i < 5000; i++) begin
         int sel, d;
         sel = int'($urandom_range(0, 3));
         d = sel == 0 ? int'($urandom_range(0, 1)) : sel == 1 ? int'($urandom_range(2, 5)) :
             sel == 2 ? int'($urandom_range(2, 12)) : int'($urandom_range(0, 60));
         step($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, d);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for a programmable integer clock divider. It owns the divide counter, accepts new divide ratios through a valid/ready handshake, and applies them only at a period boundary so the divided output never shows a truncated or stretched period. It also sequences start and stop of the divided output without runt pulses. It sits between the configuration logic and any consumer of a divided clock or a clock-enable tick.

## Interface
- W, 8: width of the divide ratio and the internal counter.
- DEF_N, 7: divide ratio loaded at reset. Must satisfy 2 ≤ DEF_N ≤ 2^W−1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request: high = run the divider, low = stop at the end of the current period.
- cfg_valid  in  1  a new divide ratio is offered.
- cfg_div  in  W  offered divide ratio N.
- cfg_ready  out  1  controller can accept a ratio; equals !pend_vld.
- cfg_err  out  1  one-cycle pulse: the accepted ratio was illegal (N < 2) and was dropped.
- div_out  out  1  divided output.
- tick  out  1  one-cycle pulse in the last cycle of each period.
- active  out  1  state is not IDLE.
- cur_div  out  W  ratio currently in effect.

## Operation
- Every output is driven directly from a flop. There is no combinational path from any input to any output.
- Internal state:
  - state: IDLE, RUN or DRAIN.
  - cnt[W−1:0].
  - cur_div.
  - pend_div and pend_vld.
- Reset values:
  - state = IDLE, cnt = 0, cur_div = DEF_N, pend_vld = 0.
  - div_out = 0, tick = 0, active = 0, cfg_err = 0, cfg_ready = 1.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - If cfg_div ≥ 2: pend_div ← cfg_div and pend_vld ← 1.
  - If cfg_div < 2: cfg_err = 1 on the next cycle and nothing is stored.
  - Only one ratio can be pending. cfg_ready stays low until the pending ratio is applied.
- IDLE:
  - cnt is held at 0; div_out and tick are 0.
  - If pend_vld is set, cur_div ← pend_div and pend_vld ← 0 on that edge.
  - If en = 1, go to RUN with cnt = 0. If a ratio is applied on the same edge, RUN starts with the new ratio.
- RUN:
  - cnt counts 0 → cur_div−1 and then wraps to 0.
  - If en = 0 when cnt < cur_div−1, go to DRAIN; counting continues.
- DRAIN:
  - Counting continues unchanged.
  - If en returns to 1 before the wrap, go back to RUN with no disturbance to the waveform.
- Wrap (cnt = cur_div−1, in RUN or DRAIN):
  - cnt ← 0.
  - If pend_vld is set, cur_div ← pend_div and pend_vld ← 0.
  - The next state is RUN if en = 1 and IDLE if en = 0.
- Output decode, for the cycle in which the counter value is k (k = cnt) and N = cur_div:
  - div_out = 1 when k < N>>1, otherwise 0. This gives 50 % duty for even N; for odd N the high phase is one cycle shorter than the low phase.
  - tick = 1 when k = N−1.
  - Both are 0 in IDLE.
- The flops must hold these values for the same cycle in which cnt = k, so the next-state decode is computed in advance.
- A new ratio never affects the period in progress. The first full period at the new ratio starts at cnt = 0.
- Reset mid-operation: on the next edge every register takes its reset value and any pending ratio is discarded.

## Timing
- Start latency: en is sampled high in IDLE at edge e. After edge e: active = 1, cnt = 0, and div_out = 1 (for N ≥ 2).
- Period: exactly cur_div cycles from one tick to the next; tick is high for 1 cycle.
- Stop: en low is honoured at the next wrap edge. After the wrap edge, active = 0 and div_out = 0. The last period is always complete.
- Config apply latency:
  - From the handshake to cur_div updating takes at most one current period plus 1 cycle.
  - In IDLE it takes 2 edges (store, then apply).
  - cfg_ready returns high on the cycle after the apply.
- Simultaneous handshake and apply:
  - cfg_ready is low while pend_vld is set, so a new ratio is never captured on the apply edge.
  - It is captured one cycle later at the earliest.

## Test plan
- Reset, then en = 1 with DEF_N = 7: per period, div_out reads 1,1,1,0,0,0,0; tick is high only in the 7th cycle of each period; cur_div = 7.
- While running at N = 7, send cfg_div = 4 at cnt = 2:
  - cfg_ready falls.
  - The current period finishes with 7 cycles.
  - The next period is 1,1,0,0 with tick in its 4th cycle; cur_div = 4.
  - cfg_ready rises after the apply.
- Drop en at cnt = 1 with N = 4: state goes to DRAIN; after 2 more cycles the wrap occurs and active = 0, div_out = 0. Repeat with en reasserted at cnt = 2: no gap in the waveform and active stays 1.
- Send cfg_div = 1 and then cfg_div = 0 in IDLE: cfg_err pulses once for each; cur_div is unchanged; cfg_ready stays 1.
- Assert rst at cnt = 3 with N = 7 and a ratio pending: after the next edge every output holds its reset value, cur_div = 7 and pend_vld = 0.
- Edge of range with W = 8, in two runs:
  - cfg_div = 255: period = 255 cycles, with 127 high and 128 low.
  - cfg_div = 2: div_out toggles every cycle and tick is high every 2nd cycle.
